stack_controller: RTL
=====================

Name: stack_controller

Overview:
Initiator-side controller that drives the 4-bit structural stack's command interface (COMMAND/INDEX/I_DATA, O_DATA back) on behalf of a host using a valid/ready request/response handshake.
- Tracks stack occupancy and rejects illegal operations before they reach the stack: overflow, underflow, and out-of-range GET.
- Sequences each command as a single-cycle strobe.
- Captures read data after a fixed stack latency and returns it with an error flag.

Parameters:
DEPTH, 5, stack capacity in entries (1..8).
STACK_LAT, 1, cycles from a POP/GET strobe on ST_COMMAND to ST_O_DATA being valid (>=1).

Ports:
CLK  in  1  clock, rising edge.
RESET  in  1  asynchronous, active-low reset.
REQ_VALID  in  1  host request valid.
REQ_READY  out  1  controller can accept a request.
REQ_OP  in  2  00 CLEAR, 01 PUSH, 10 POP, 11 GET.
REQ_INDEX  in  3  GET index, 0 = top of stack.
REQ_DATA  in  4  PUSH data.
RSP_VALID  out  1  response valid.
RSP_READY  in  1  host accepts the response.
RSP_DATA  out  4  POP/GET data; 0 for PUSH, CLEAR and errors.
RSP_ERR  out  1  request rejected.
ST_COMMAND  out  2  stack command: 00 NOP, 01 PUSH, 10 POP, 11 GET.
ST_INDEX  out  3  stack INDEX.
ST_I_DATA  out  4  stack I_DATA.
ST_RESET  out  1  active-high stack reset.
ST_O_DATA  in  4  stack O_DATA.
DEPTH_O  out  4  current occupancy, 0..DEPTH.

Behaviour:
- Reset (RESET=0, asynchronous):
  - State IDLE, depth 0, REQ_READY 0, RSP_VALID 0, RSP_DATA 0, RSP_ERR 0.
  - ST_COMMAND NOP, ST_INDEX 0, ST_I_DATA 0.
  - ST_RESET 1, so the stack is held in reset.
  - Reset mid-operation abandons the request; no response is produced.
- First edge after RESET rises: ST_RESET 0, REQ_READY 1.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - REQ_READY=1; a request is accepted on an edge with REQ_VALID=1 (cycle A).
  - The request is checked against depth at acceptance.
  - Errors: PUSH with depth==DEPTH; POP with depth==0; GET with REQ_INDEX>=depth.
  - On error: go to RESP, RSP_ERR=1, RSP_DATA=0. No stack command is issued and depth is unchanged. RSP_VALID is high in cycle A+1.
  - On a legal request: go to ISSUE.
- ISSUE (cycle A+1, exactly one cycle):
  - ST_COMMAND = op (CLEAR drives NOP and ST_RESET=1 instead).
  - ST_INDEX = REQ_INDEX for GET, else 0.
  - ST_I_DATA = REQ_DATA for PUSH, else 0.
  - Depth updates at the end of this cycle: PUSH +1, POP -1, CLEAR 0.
  - PUSH and CLEAR then go to RESP. POP and GET go to WAIT.
- WAIT:
  - ST_COMMAND=NOP and ST_RESET=0.
  - Counts STACK_LAT cycles, then samples ST_O_DATA into RSP_DATA and goes to RESP.
- RESP:
  - RSP_VALID=1; RSP_DATA and RSP_ERR are held stable until RSP_READY=1.
  - Then return to IDLE; REQ_READY is high the next cycle. There is no back-to-back acceptance in the same cycle.
- REQ_READY is 0 in every state other than IDLE. REQ_* inputs are registered at acceptance, so the host may change them afterwards.
- Latency:
  - PUSH/CLEAR: RSP_VALID in cycle A+2.
  - POP/GET: RSP_VALID in cycle A+2+STACK_LAT.
  - Error: RSP_VALID in cycle A+1.
- DEPTH_O reflects depth after every update; it never exceeds DEPTH and never wraps below 0.
- CLEAR is always legal, including when depth is already 0.

Decomposition:
- Package stack_ctrl_pkg holds:
  - stack command constants NOP/PUSH/POP/GET (00/01/10/11);
  - host op enum (CLEAR/PUSH/POP/GET);
  - state enum (IDLE/ISSUE/WAIT/RESP).
- One sub-module, stack_ctrl_depth:
  - saturating occupancy counter with inc/dec/clr inputs;
  - full/empty outputs and an index-in-range compare.
- The FSM and datapath stay in stack_controller.

Test Plan:
1. Reset held low for 3 cycles, then released: ST_RESET=1 and all other outputs 0 during reset; ST_RESET=0, REQ_READY=1, DEPTH_O=0 one cycle after release.
2. PUSH 1..5 (DEPTH=5, STACK_LAT=1), each with RSP_READY=1: one ST_COMMAND=01 strobe per push carrying ST_I_DATA 1..5; every RSP_ERR=0; DEPTH_O=5.
3. Sixth PUSH with data 6: RSP_ERR=1 in cycle A+1; ST_COMMAND stays 00; DEPTH_O stays 5.
4. Stack model returns the top-indexed entry. GET index 0..4 returns RSP_DATA 5,4,3,2,1 with RSP_VALID at A+3. GET index 5 or 7 returns RSP_ERR=1, RSP_DATA=0.
5. Five POPs return 5,4,3,2,1 and DEPTH_O reaches 0. A sixth POP returns RSP_ERR=1 with no stack strobe.
6. Backpressure and reset:
   - RSP_READY held 0 for 4 cycles on a GET: RSP_VALID and RSP_DATA stay stable and REQ_READY stays 0.
   - CLEAR after 3 pushes: ST_RESET pulses for exactly 1 cycle and DEPTH_O=0.
   - RESET asserted during WAIT: no response after release and DEPTH_O=0.

Source files
------------

// File: rtl/stack_ctrl_pkg.sv
// Shared command, op and state types for the
// stack command controller.
package stack_ctrl_pkg;

  localparam logic [1:0] CMD_NOP  = 2'b00;
  localparam logic [1:0] CMD_PUSH = 2'b01;
  localparam logic [1:0] CMD_POP  = 2'b10;
  localparam logic [1:0] CMD_GET  = 2'b11;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'b00,
    OP_PUSH  = 2'b01,
    OP_POP   = 2'b10,
    OP_GET   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  typedef struct packed {
    op_e        op;
    logic [2:0] index;
    logic [3:0] data;
  } req_t;

endpackage

// File: rtl/stack_ctrl_depth.sv
// Saturating stack occupancy counter with
// full/empty flags and GET index range check.
module stack_ctrl_depth #(
  parameter int DEPTH = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       dec,
  input  logic       clr,
  input  logic [2:0] index,
  output logic [3:0] depth,
  output logic       full,
  output logic       empty,
  output logic       idx_ok
);

  assign full   = (depth == 4'(DEPTH));
  assign empty  = (depth == 4'd0);
  assign idx_ok = ({1'b0, index} < depth);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth <= 4'd0;
    end else if (clr) begin
      depth <= 4'd0;
    end else if (inc && !full) begin
      depth <= depth + 4'd1;
    end else if (dec && !empty) begin
      depth <= depth - 4'd1;
    end
  end

endmodule

// File: rtl/stack_controller.sv
// Host-side controller sequencing single-cycle
// strobes to the structural stack.
module stack_controller
  import stack_ctrl_pkg::*;
#(
  parameter int DEPTH     = 5,
  parameter int STACK_LAT = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic [1:0] REQ_OP,
  input  logic [2:0] REQ_INDEX,
  input  logic [3:0] REQ_DATA,
  output logic       RSP_VALID,
  input  logic       RSP_READY,
  output logic [3:0] RSP_DATA,
  output logic       RSP_ERR,
  output logic [1:0] ST_COMMAND,
  output logic [2:0] ST_INDEX,
  output logic [3:0] ST_I_DATA,
  output logic       ST_RESET,
  input  logic [3:0] ST_O_DATA,
  output logic [3:0] DEPTH_O
);

  localparam int CW = (STACK_LAT > 1) ? $clog2(STACK_LAT) : 1;

  state_e        state, state_n;
  req_t          req, req_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          req_ready_n, rsp_valid_n, rsp_err_n, st_reset_n;
  logic [3:0]    rsp_data_n, st_idata_n;
  logic [1:0]    st_cmd_n;
  logic [2:0]    st_index_n;
  logic          full, empty, idx_ok, bad;
  logic          inc, dec, clr;
  op_e           op_in;

  assign op_in = op_e'(REQ_OP);
  assign inc   = (state == S_ISSUE) && (req.op == OP_PUSH);
  assign dec   = (state == S_ISSUE) && (req.op == OP_POP);
  assign clr   = (state == S_ISSUE) && (req.op == OP_CLEAR);

  stack_ctrl_depth #(.DEPTH(DEPTH)) u_depth (
    .clk    (CLK),
    .rst_n  (RESET),
    .inc    (inc),
    .dec    (dec),
    .clr    (clr),
    .index  (REQ_INDEX),
    .depth  (DEPTH_O),
    .full   (full),
    .empty  (empty),
    .idx_ok (idx_ok)
  );

  always_comb begin
    bad = 1'b0;
    unique case (1'b1)
      op_in == OP_PUSH: bad = full;
      op_in == OP_POP:  bad = empty;
      op_in == OP_GET:  bad = !idx_ok;
      default:          bad = 1'b0;
    endcase
  end

  always_comb begin
    state_n     = state;
    req_n       = req;
    cnt_n       = cnt;
    req_ready_n = REQ_READY;
    rsp_valid_n = RSP_VALID;
    rsp_data_n  = RSP_DATA;
    rsp_err_n   = RSP_ERR;
    st_cmd_n    = CMD_NOP;
    st_index_n  = 3'd0;
    st_idata_n  = 4'd0;
    st_reset_n  = 1'b0;
    unique case (state)
      S_IDLE: begin
        req_ready_n = 1'b1;
        if (REQ_READY && REQ_VALID) begin
          req_n       = '{op: op_in, index: REQ_INDEX, data: REQ_DATA};
          req_ready_n = 1'b0;
          if (bad) begin
            state_n     = S_RESP;
            rsp_valid_n = 1'b1;
            rsp_err_n   = 1'b1;
            rsp_data_n  = 4'd0;
          end else begin
            state_n = S_ISSUE;
            // CLEAR resets the stack rather than sending a command
            st_reset_n = (op_in == OP_CLEAR);
            st_cmd_n   = (op_in == OP_CLEAR) ? CMD_NOP : REQ_OP;
            st_index_n = (op_in == OP_GET) ? REQ_INDEX : 3'd0;
            st_idata_n = (op_in == OP_PUSH) ? REQ_DATA : 4'd0;
          end
        end
      end
      S_ISSUE: begin
        if (req.op == OP_PUSH || req.op == OP_CLEAR) begin
          state_n     = S_RESP;
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b0;
          rsp_data_n  = 4'd0;
        end else begin
          state_n = S_WAIT;
          cnt_n   = '0;
        end
      end
      S_WAIT: begin
        if (cnt == CW'(STACK_LAT - 1)) begin
          state_n     = S_RESP;
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b0;
          rsp_data_n  = ST_O_DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_RESP: begin
        if (RSP_READY) begin
          state_n     = S_IDLE;
          rsp_valid_n = 1'b0;
          rsp_err_n   = 1'b0;
          rsp_data_n  = 4'd0;
          req_ready_n = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= S_IDLE;
      req        <= '0;
      cnt        <= '0;
      REQ_READY  <= 1'b0;
      RSP_VALID  <= 1'b0;
      RSP_DATA   <= 4'd0;
      RSP_ERR    <= 1'b0;
      ST_COMMAND <= CMD_NOP;
      ST_INDEX   <= 3'd0;
      ST_I_DATA  <= 4'd0;
      ST_RESET   <= 1'b1;
    end else begin
      state      <= state_n;
      req        <= req_n;
      cnt        <= cnt_n;
      REQ_READY  <= req_ready_n;
      RSP_VALID  <= rsp_valid_n;
      RSP_DATA   <= rsp_data_n;
      RSP_ERR    <= rsp_err_n;
      ST_COMMAND <= st_cmd_n;
      ST_INDEX   <= st_index_n;
      ST_I_DATA  <= st_idata_n;
      ST_RESET   <= st_reset_n;
    end
  end

endmodule
